// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I memory request at a time, drives the
// data-memory controller with word address, lane mask and replicated store
// data, then returns an extended load result or raises a one-cycle exception.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] store_data,
  output logic [31:0] address,
  output logic [31:0] datain,
  output logic        wen,
  output logic        ren,
  output logic [3:0]  byte_select_vector,
  input  logic        memReady,
  input  logic [31:0] dataout,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        exc_misaligned,
  output logic        exc_illegal,
  output logic        exc_timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Last BUSY cycle index before giving up on memReady.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] load_q, load_d;
  logic        mis_q, mis_d;
  logic        ill_q, ill_d;
  logic        to_q, to_d;

  logic dir_ok, f3_ok, misaligned, busy;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] sd);
    case (size)
      2'b00:   replicate = {4{sd[7:0]}};
      2'b01:   replicate = {2{sd[15:0]}};
      default: replicate = sd;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
      3'b100:  extract = {24'd0, sh[7:0]};
      3'b101:  extract = {16'd0, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  // Request classification: direction, width code legality and alignment.
  always_comb begin
    dir_ok     = req_read ^ req_write;
    f3_ok      = req_write ? (funct3 inside {3'b000, 3'b001, 3'b010})
                           : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Next-state, latched request fields, stall and exception pulses.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    write_d = write_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    mis_d   = 1'b0;
    ill_d   = 1'b0;
    to_d    = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!(dir_ok && f3_ok)) begin
            ill_d = 1'b1;
          end else if (misaligned) begin
            mis_d = 1'b1;
          end else begin
            stall   = 1'b1;
            addr_d  = req_addr;
            f3_d    = funct3;
            write_d = req_write;
            wdata_d = replicate(funct3[1:0], store_data);
            cnt_d   = 8'd0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (memReady) begin
          load_d  = write_q ? 32'd0 : extract(f3_q, addr_q[1:0], dataout);
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset clears everything including data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      load_q  <= '0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
    end
  end

  // Controller-facing outputs are driven only from latched state.
  always_comb begin
    busy               = (state_q == BUSY);
    address            = {addr_q[31:2], 2'b00};
    datain             = wdata_q;
    ren                = busy && !write_q;
    wen                = busy && write_q;
    byte_select_vector = busy ? lane_mask(f3_q[1:0], addr_q[1:0]) : 4'b0000;
    resp_valid         = (state_q == DONE);
    load_data          = load_q;
    exc_misaligned     = mis_q;
    exc_illegal        = ill_q;
    exc_timeout        = to_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues requests and plays the
// memory controller, a monitor checks accesses and completions against a
// queue of expectations computed from the architectural rules.
module tb_load_store_unit;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_read, req_write;
  logic [2:0]  funct3;
  logic [31:0] req_addr, store_data;
  logic [31:0] address, datain;
  logic        wen, ren;
  logic [3:0]  byte_select_vector;
  logic        memReady;
  logic [31:0] dataout;
  logic        stall, resp_valid;
  logic [31:0] load_data;
  logic        exc_misaligned, exc_illegal, exc_timeout;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .funct3(funct3), .req_addr(req_addr),
    .store_data(store_data), .address(address), .datain(datain), .wen(wen),
    .ren(ren), .byte_select_vector(byte_select_vector), .memReady(memReady),
    .dataout(dataout), .stall(stall), .resp_valid(resp_valid),
    .load_data(load_data), .exc_misaligned(exc_misaligned),
    .exc_illegal(exc_illegal), .exc_timeout(exc_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // flags = {resp, misaligned, illegal, timeout}
  typedef struct {
    logic [3:0]  flags;
    logic [31:0] ld;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  bsv;
    logic        wr;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rdata, input int w, input int c0);
    exp_t e;
    int n, off, m;
    longint v;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    m = ((1 << n) - 1) << off;
    e.addr = a & ~32'd3;
    e.bsv  = m[3:0];
    e.din  = (n == 1) ? sd[7:0] * 32'h0101_0101 : (n == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    e.wr   = wr;
    e.ld   = 32'd0;
    if (rd == wr || f3 == 3'd3 || f3 > 3'd5 || (wr && f3 > 3'd2)) begin
      e.flags = 4'b0010; e.cyc = c0 + 1;
    end else if (off % n != 0) begin
      e.flags = 4'b0100; e.cyc = c0 + 1;
    end else if (w >= T) begin
      e.flags = 4'b0001; e.cyc = c0 + T + 1;
    end else begin
      e.flags = 4'b1000; e.cyc = c0 + w + 2;
      if (rd) begin
        v = rdata;
        v = v >> (8 * off);
        v = v % (64'd1 << (8 * n));
        if (n < 4 && !f3[2] && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        e.ld = v[31:0];
      end
    end
    return e;
  endfunction

  // Monitor: checks every memory access against the outstanding request and
  // every completion/exception pulse against the head of the queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (ren || wen) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL access: ren=%b wen=%b with no request outstanding", ren, wen);
        end else begin
          chk("access_legal", 32'((q[0].flags & 4'b1001) != 0), 32'd1);
          chk("address", address, q[0].addr);
          chk("byte_select", 32'(byte_select_vector), 32'(q[0].bsv));
          chk("wen", 32'(wen), 32'(q[0].wr));
          chk("ren", 32'(ren), 32'(!q[0].wr));
          if (q[0].wr) chk("datain", datain, q[0].din);
        end
      end else begin
        chk("byte_select_idle", 32'(byte_select_vector), 32'd0);
      end
      if (resp_valid || exc_misaligned || exc_illegal || exc_timeout) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pulse: got %b%b%b%b with no request outstanding",
                   resp_valid, exc_misaligned, exc_illegal, exc_timeout);
        end else begin
          me = q.pop_front();
          chk("pulse_kind", {28'd0, resp_valid, exc_misaligned, exc_illegal, exc_timeout},
              {28'd0, me.flags});
          chk("pulse_cycle", cyc, me.cyc);
          if (resp_valid) chk("load_data", load_data, me.ld);
        end
      end
    end
  end

  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdata, input int w, input bit early);
    exp_t e;
    if (prev_done && !early) @(negedge clk);
    req_valid = 1'b1; req_read = rd; req_write = wr; funct3 = f3;
    req_addr = a; store_data = sd;
    if (prev_done && early) begin
      #1 chk("stall_done_ignored", 32'(stall), 32'd0);
      @(negedge clk);
    end
    prev_done = 1'b0;
    e = model(rd, wr, f3, a, sd, rdata, w, cyc);
    q.push_back(e);
    #1 chk("stall_accept", 32'(stall), 32'(e.flags[3] | e.flags[0]));
    @(negedge clk);
    req_valid = 1'b0; req_read = 1'($urandom); req_write = 1'($urandom);
    funct3 = 3'($urandom); req_addr = $urandom; store_data = $urandom;
    if (e.flags[3] | e.flags[0]) begin
      for (int i = 0; ; i++) begin
        memReady = (i == w);
        dataout  = (i == w) ? rdata : $urandom;
        #1 chk("stall_busy", 32'(stall), 32'd1);
        @(negedge clk);
        if (i == w) begin
          memReady = 1'b0; dataout = $urandom; prev_done = 1'b1;
          #1 chk("stall_done", 32'(stall), 32'd0);
          break;
        end
        if (i == T - 1) break;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic rd, wr, en;
    logic [2:0] f3;
    logic [31:0] a;
    int r;
    logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    reset = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    funct3 = 3'd0; req_addr = 32'd0; store_data = 32'd0;
    memReady = 1'b0; dataout = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_address", address, 32'd0);
    chk("reset_datain", datain, 32'd0);
    chk("reset_load_data", load_data, 32'd0);
    chk("reset_ctrl", {22'd0, ren, wen, stall, resp_valid, exc_misaligned, exc_illegal,
                       exc_timeout, byte_select_vector}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_txn(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 0);   // LB
    run_txn(0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 0);   // SH
    run_txn(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 0);           // LW misaligned
    run_txn(1, 0, 3'b101, 32'h0000_4002, 32'h0, 32'h9234_0000, 3, 0);   // LHU, 3 waits
    run_txn(1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'h0, T + 1, 0);       // timeout
    run_txn(1, 0, 3'b100, 32'h0000_6001, 32'h0, 32'h1234_F056, T - 1, 0); // ready on last cycle
    run_txn(0, 1, 3'b000, 32'h0000_7003, 32'h1234_56A5, 32'h0, 1, 0);   // SB
    run_txn(1, 1, 3'b000, 32'h0000_8000, 32'h0, 32'h0, 0, 1);           // both directions
    run_txn(0, 1, 3'b100, 32'h0000_9000, 32'h0, 32'h0, 0, 0);           // store with BU code
    run_txn(1, 0, 3'b001, 32'h0000_A002, 32'h0, 32'h8001_7FFF, 0, 0);   // LH sign
    run_txn(1, 0, 3'b001, 32'h0000_B000, 32'h0, 32'h1111_2222, 2, 1);   // presented in DONE

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 11);
      if (r == 0)      begin rd = 1; wr = 1; end
      else if (r == 1) begin rd = 0; wr = 0; end
      else             begin rd = 1'(r % 2); wr = !rd; end
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1]) a[1:0] = 2'b00;
        else if (f3[0]) a[0] = 1'b0;
      end
      en = 1'($urandom);
      run_txn(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, T + 1), en);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(negedge clk);
        prev_done = 1'b0;
      end
    end

    // Reset in the second BUSY cycle discards the transaction
    repeat (2) @(negedge clk);
    prev_done = 1'b0;
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; funct3 = 3'b000;
    req_addr = 32'h0000_1003; store_data = 32'd0;
    q.push_back(model(1, 0, 3'b000, 32'h0000_1003, 32'd0, 32'd0, 0, cyc));
    @(negedge clk);
    req_valid = 1'b0; memReady = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy_ren", 32'(ren), 32'd0);
    chk("rst_busy_stall", 32'(stall), 32'd0);
    chk("rst_busy_resp", 32'(resp_valid), 32'd0);
    chk("rst_busy_address", address, 32'd0);
    chk("rst_busy_bsv", 32'(byte_select_vector), 32'd0);
    q.delete();
    reset = 1'b0; memReady = 1'b1; dataout = 32'hFFFF_FFFF;
    repeat (4) @(negedge clk);
    memReady = 1'b0;
    repeat (2) @(negedge clk);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
